receiver_axis: RTL
==================

// Module: receiver_axis
// PURPOSE
//   UART serial receiver with an AXI4-Stream master output. It is the receive-side
//   counterpart of the AXIS UART transmitter: it consumes the asynchronous serial
//   line (8N1-style frame: 1 start bit, WORD_WIDTH data bits LSB first, 1 stop bit)
//   and presents each received word as one AXIS beat.
//   The block holds one word of buffering and reports framing and overrun errors.
// PARAMETERS
//   CLOCK_FREQUENCY  32'd100_000_000  clk frequency in Hz
//   BAUD_RATE        32'd115200       line bit rate; CPB = CLOCK_FREQUENCY/BAUD_RATE (integer div); CPB >= 4 required
//   WORD_WIDTH       32'd8            data bits per frame
// PORTS
//   clk               in   1           clock
//   rst               in   1           reset, synchronous, active-high
//   din               in   1           serial line, asynchronous to clk, idle high
//   dout_axis_tdata   out  WORD_WIDTH  received word
//   dout_axis_tvalid  out  1           tdata holds an unconsumed word
//   dout_axis_tready  in   1           downstream accepts the beat
//   frame_error       out  1           1-cycle pulse: stop bit sampled low
//   overrun           out  1           1-cycle pulse: word completed while the buffer was still full
// BEHAVIOUR
// - din passes through a 2-flop synchronizer (flops reset to 1) -> din_s. All decisions use din_s.
// - Bit counter is 32-bit. HALF = CPB/2.
// - FSM states:
//   - IDLE: on din_s==0 -> START, counter=0.
//   - START: count up. At counter==HALF-1, sample:
//     - 0 -> DATA, counter=0, bit index=0.
//     - 1 -> glitch, back to IDLE (no outputs).
//   - DATA: at counter==CPB-1 (mid-bit), sample into the shift register (LSB first), counter=0.
//     After WORD_WIDTH samples -> STOP.
//   - STOP: at counter==CPB-1, sample:
//     - 1 -> commit word, -> IDLE (mid stop bit, so the next start edge is caught).
//     - 0 -> frame_error=1 for one cycle, word discarded, -> BREAK.
//   - BREAK: wait for din_s==1, then -> IDLE. A held-low line never re-triggers.
// - Commit (cycle after the stop sample):
//   - buffer empty, or tvalid&&tready in that same cycle: load tdata, tvalid=1.
//   - buffer full and tready=0: overrun=1 for one cycle; new word dropped, old tdata/tvalid kept.
// - AXIS rules:
//   - tvalid stays 1 and tdata stays stable until tvalid&&tready.
//   - tvalid falls the cycle after the handshake unless a commit coincides.
//   - tready never affects reception.
// - Latency: tvalid rises (WORD_WIDTH+1)*CPB + HALF + 3 cycles (+/-1) after the din falling edge.
// - Reset values: tvalid=0, tdata=0, frame_error=0, overrun=0, FSM=IDLE, counter=0.
//   rst mid-frame aborts the frame; no pulses are emitted for it.
// CONFIGURATION
//   RX_MAJORITY_VOTE_EN defined:
//     each sample (start, data, stop) = majority of the last 3 din_s values at the sample cycle
//     (3-bit history register, reset 3'b111). Rejects single-cycle glitches.
//   Undefined:
//     each sample = din_s at the sample cycle; no history register.
// TESTING  (CLOCK_FREQUENCY=16, BAUD_RATE=1 -> CPB=16, WORD_WIDTH=8)
//   1. Frame 0xA5, tready=1 -> exactly one beat with tdata=0xA5; frame_error=0, overrun=0.
//   2. tready=0; frames 0x3C then 0x81 -> tdata holds 0x3C, overrun pulses once after 2nd stop bit;
//      raising tready -> one beat of 0x3C, then tvalid=0.
//   3. din low for 4 cycles then high -> returns to IDLE; no tvalid, no error pulse.
//   4. Frame 0x55 with stop bit low, line held low 3 bit times -> one frame_error pulse, no tvalid,
//      no re-trigger; after the line goes high, frame 0x12 -> tdata=0x12.
//   5. rst for 1 cycle mid-data of frame 0x77 -> tvalid=0, no pulses; next frame 0xC3 received correctly.
//   6. Frame 0x00 with a 1-cycle high glitch at data bit 0 mid-sample -> 0x00 with RX_MAJORITY_VOTE_EN,
//      0x01 without it.

Source files
------------

// File: rtl/receiver_axis.sv
// receiver_axis: UART serial receiver with an AXI4-Stream master output.
//
// Receives frames of 1 start bit, WORD_WIDTH data bits (LSB first) and 1 stop bit.
// Each good word becomes one AXIS beat. There is one word of output buffering.
// A stop bit sampled low raises a frame_error pulse and drops the word. A word that
// completes while the buffer is still full raises an overrun pulse and is dropped.
//
// Parameters:
//   CLOCK_FREQUENCY  clk frequency in Hz
//   BAUD_RATE        line bit rate; CPB = CLOCK_FREQUENCY/BAUD_RATE, must be >= 4
//   WORD_WIDTH       data bits per frame
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   din               serial line (asynchronous, idle high)
//   dout_axis_tdata   received word
//   dout_axis_tvalid  tdata holds an unconsumed word
//   dout_axis_tready  downstream accepts the beat
//   frame_error       1-cycle pulse, stop bit sampled low
//   overrun           1-cycle pulse, word completed while buffer full
//
// Optional feature macro: RX_MAJORITY_VOTE_EN
//   When defined, every start/data/stop sample is the majority of the last three
//   synchronized line values, which rejects single-cycle glitches.
module receiver_axis #(
  parameter logic [31:0] CLOCK_FREQUENCY = 32'd100_000_000,
  parameter logic [31:0] BAUD_RATE       = 32'd115200,
  parameter logic [31:0] WORD_WIDTH      = 32'd8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  din,
  output logic [WORD_WIDTH-1:0] dout_axis_tdata,
  output logic                  dout_axis_tvalid,
  input  logic                  dout_axis_tready,
  output logic                  frame_error,
  output logic                  overrun
);

  localparam logic [31:0] CPB  = CLOCK_FREQUENCY / BAUD_RATE;
  localparam logic [31:0] HALF = CPB / 32'd2;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  logic                  din_m_q, din_m_d;
  logic                  din_s_q, din_s_d;
  state_t                state_q, state_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [31:0]           bit_q, bit_d;
  logic [WORD_WIDTH-1:0] shift_q, shift_d;
  logic                  commit_q, commit_d;
  logic                  fe_q, fe_d;
  logic                  ov_q, ov_d;
  logic                  tvalid_q, tvalid_d;
  logic [WORD_WIDTH-1:0] tdata_q, tdata_d;
  logic                  samp;

`ifdef RX_MAJORITY_VOTE_EN
  // hist_q[0] always equals din_s_q, so the vote covers the current synchronized
  // value and the two before it.
  logic [2:0] hist_q, hist_d;

  always_comb hist_d = {hist_q[1:0], din_m_q};

  always_ff @(posedge clk) begin
    if (rst) hist_q <= 3'b111;
    else     hist_q <= hist_d;
  end

  assign samp = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
`else
  assign samp = din_s_q;
`endif

  always_comb begin
    din_m_d  = din;
    din_s_d  = din_m_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    commit_d = 1'b0;
    fe_d     = 1'b0;
    ov_d     = 1'b0;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;

    case (state_q)
      S_IDLE: begin
        if (!din_s_q) begin
          state_d = S_START;
          cnt_d   = 32'd0;
        end
      end
      S_START: begin
        // Re-check the line mid start bit; a high sample was only a glitch.
        if (cnt_q == HALF - 32'd1) begin
          cnt_d = 32'd0;
          if (!samp) begin
            state_d = S_DATA;
            bit_d   = 32'd0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_DATA: begin
        if (cnt_q == CPB - 32'd1) begin
          cnt_d   = 32'd0;
          shift_d = {samp, shift_q[WORD_WIDTH-1:1]};
          if (bit_q == WORD_WIDTH - 32'd1) state_d = S_STOP;
          else                             bit_d   = bit_q + 32'd1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_STOP: begin
        // Leaving at mid stop bit lets IDLE catch an immediately following start edge.
        if (cnt_q == CPB - 32'd1) begin
          cnt_d = 32'd0;
          if (samp) begin
            commit_d = 1'b1;
            state_d  = S_IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_BREAK: begin
        // A line held low must return high before a new frame may start.
        if (din_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Output buffer: a handshake frees the slot in the same cycle a commit loads it.
    if (tvalid_q && dout_axis_tready) tvalid_d = 1'b0;
    if (commit_q) begin
      if (!tvalid_q || dout_axis_tready) begin
        tvalid_d = 1'b1;
        tdata_d  = shift_q;
      end else begin
        ov_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      din_m_q  <= 1'b1;
      din_s_q  <= 1'b1;
      state_q  <= S_IDLE;
      cnt_q    <= 32'd0;
      bit_q    <= 32'd0;
      shift_q  <= '0;
      commit_q <= 1'b0;
      fe_q     <= 1'b0;
      ov_q     <= 1'b0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
    end else begin
      din_m_q  <= din_m_d;
      din_s_q  <= din_s_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      commit_q <= commit_d;
      fe_q     <= fe_d;
      ov_q     <= ov_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
    end
  end

  assign dout_axis_tdata  = tdata_q;
  assign dout_axis_tvalid = tvalid_q;
  assign frame_error      = fe_q;
  assign overrun          = ov_q;

endmodule
